// File: rtl/vga_pkg.sv
// Shared timing constants for the 1024x768 @ 60 Hz raster, derived sync
// window bounds and the colour-bar palette used by the optional test pattern.
package vga_pkg;

    localparam int CNT_W    = 11;
    localparam int RGB_W    = 12;

    localparam int H_ACTIVE = 1024;
    localparam int H_FRONT  = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BACK   = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 768;
    localparam int V_FRONT  = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int HSYNC_START = H_ACTIVE + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int VSYNC_START = V_ACTIVE + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 12'hfff;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 12'hff0;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 12'h0ff;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 12'h0f0;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 12'hf0f;
    localparam logic [RGB_W-1:0] BAR_RED     = 12'hf00;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 12'h00f;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 12'h000;

    // Eight 128-pixel bars, left to right, selected by hcount[9:7].
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        c = BAR_BLACK;
        case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bundle passed down the draw chain. Sync and blank are logical
// active-high here; pin polarity is applied at the board output stage.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

// File: rtl/vga_timing_cnt.sv
// Generic wrap counter: counts 0..MAX while en is high, then returns to 0.
// wrap flags the terminal count so a cascaded counter can be enabled by it.
module vga_timing_cnt #(
    parameter int MAX = vga_pkg::H_TOTAL - 1,
    parameter int W   = vga_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    import vga_pkg::*;

    assign wrap = (cnt == W'(MAX));

    // Advance on enable, returning to zero after the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 1024x768 @ 60 Hz raster source. Two cascaded wrap counters give the current
// position; blank/sync/colour are decoded from it and registered together so
// every field of vga_out describes the same pixel, one cycle behind the
// counters. Optional colour-bar test pattern: VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    vga_if.out                vga_out,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_en;

    logic             hblnk_d;
    logic             hsync_d;
    logic             vblnk_d;
    logic             vsync_d;
    logic             origin;
    logic             frame_done;

    assign v_en = en & h_wrap;

    vga_timing_cnt #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    vga_timing_cnt #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (v_en),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // Decode blank/sync windows from the current counter position.
    always_comb begin
        hblnk_d = (h_cnt >= CNT_W'(H_ACTIVE));
        hsync_d = (h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END));
        vblnk_d = (v_cnt >= CNT_W'(V_ACTIVE));
        vsync_d = (v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END));
        origin  = (h_cnt == '0) && (v_cnt == '0);
    end

    // A frame completes when both counters wrap; the count is published when
    // the output stage shows (0,0) so it lines up with frame_start. Reset
    // clears the pending flag, so an aborted frame is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else if (en && h_wrap && v_wrap) begin
            frame_done <= 1'b1;
        end else if (en && origin) begin
            frame_done <= 1'b0;
        end
    end

    // Output stage: capture the decoded pixel; hold everything while en is low.
    // frame_start is qualified by en so a stall at (0,0) yields a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            frame_start    <= 1'b0;
            frame_cnt      <= '0;
        end else if (en) begin
            vga_out.hcount <= h_cnt;
            vga_out.vcount <= v_cnt;
            vga_out.hsync  <= hsync_d;
            vga_out.vsync  <= vsync_d;
            vga_out.hblnk  <= hblnk_d;
            vga_out.vblnk  <= vblnk_d;
            frame_start    <= origin;
            if (origin && frame_done) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end else begin
            frame_start    <= 1'b0;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    // Colour bars during active video, black in blanking, same stage as above.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.rgb <= '0;
        end else if (en) begin
            vga_out.rgb <= (hblnk_d || vblnk_d) ? '0 : bar_colour(h_cnt[9:7]);
        end
    end
`else
    assign vga_out.rgb = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source end of the `vga_if` pixel stream. Generates the 1024x768 @ 60 Hz raster (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) consumed by the drawing chain, which includes the background, sprite, start-screen and finish-screen stages. Also provides a per-frame strobe and a frame counter, used by game logic for frame-synchronous updates such as animation and physics ticks. Sits directly after the pixel-clock domain entry, ahead of every `draw_*` stage.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FRONT`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width
- `H_BACK`, 160, horizontal back porch; H_TOTAL = 1344
- `V_ACTIVE`, 768, visible lines
- `V_FRONT`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width
- `V_BACK`, 29, vertical back porch; V_TOTAL = 806
- `FCNT_W`, 16, frame counter width

Ports:
- `clk`  in  1  pixel clock, 65 MHz
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  advance raster; when low, all state and outputs hold
- `vga_out`  vga_if.out  bundle  hcount/vcount (11 b), hsync, vsync, hblnk, vblnk, rgb (12 b)
- `frame_start`  out  1  one-cycle pulse coincident with output pixel (0,0)
- `frame_cnt`  out  FCNT_W  completed-frame count

## Operation
- Internal counters `h_cnt` ∈ [0, H_TOTAL-1] and `v_cnt` ∈ [0, V_TOTAL-1] advance once per `en` cycle.
- `h_cnt` wraps H_TOTAL-1 → 0. On that wrap, `v_cnt` increments, and wraps V_TOTAL-1 → 0.
- Derived signals, all decoded from the counter values:
  - hblnk = h_cnt ≥ H_ACTIVE
  - hsync = H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC, i.e. 1048..1183
  - vblnk = v_cnt ≥ V_ACTIVE
  - vsync = 771 ≤ v_cnt < 777
- Sync and blank signals are logical active-high on `vga_if`. Pin polarity is applied at the top-level output stage, not here.
- `frame_start` = 1 when the registered output position is (0,0).
- `frame_cnt` increments by 1 when `v_cnt` wraps to 0. It rolls over modulo 2^FCNT_W without saturating.
- `rgb` is 12'h000 unless the test pattern is compiled in (see Configuration).
- `en` low for k cycles stretches the raster by k cycles with no skipped or repeated positions. `frame_start` does not re-pulse while held at (0,0).

## Timing
- All outputs are registered.
- Output position n appears one cycle after the counters reach n. Counters and outputs are pipelined so that every output field in a given cycle describes the same pixel.
- Reset values:
  - counters = 0
  - all `vga_out` fields = 0
  - frame_start = 0
  - frame_cnt = 0
- First `en` cycle after reset release: outputs hcount=0, vcount=0, blanks=0, syncs=0, frame_start=1.
- Line period is 1344 en-cycles; frame period is 1 083 264 en-cycles.
- Reset asserted mid-frame: the next cycle shows all-zero outputs. The raster restarts at (0,0), and no partial-frame `frame_cnt` increment occurs.
- `rst` has priority over `en`.

## Configuration
- `VGA_TIMING_TEST_PATTERN_EN` defined: during active video, rgb shows 8 vertical colour bars of 128 px, selected by hcount[9:7]. In order the bars are fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000. rgb = 000 during blanking. The pattern is registered in the same stage as the other outputs.
- Macro undefined: rgb is constant 12'h000, and the pattern logic is absent.

## Structure
- `vga_pkg` holds:
  - the timing constants: H_/V_ ACTIVE, FRONT, SYNC, BACK, TOTAL
  - derived sync start/end localparams
  - the bar colour constants
- Module parameters default to those constants.
- Sub-module `vga_timing_cnt`: a generic wrap counter (parameters MAX and width; ports en, wrap output), instantiated for h and v. The v instance is enabled by en & h_wrap.

## Test plan
- Reset 5 cycles, en=1 → cycle 1 after release: hcount=0, vcount=0, frame_start=1. hcount reaches 1023 with hblnk=0, then 1024 with hblnk=1.
- Run one line → hsync high for exactly 136 cycles, hcount 1048..1183. hcount wraps 1343 → 0 while vcount 0 → 1.
- Run a full frame → vsync high on lines 771..776 only, vblnk on 768..805. frame_cnt goes 0 → 1 when (0,0) is reached. frame_start pulses once per 1 083 264 cycles.
- Drop en for 10 cycles at hcount=500 → all outputs frozen for the 10 cycles, then resume at 501. frame_start does not re-pulse on an en stall at (0,0).
- Assert rst at hcount=700, vcount=300 → next cycle all outputs 0, frame_cnt unchanged from reset value 0. Raster restarts at (0,0).
- With the macro defined: rgb=fff at hcount 0..127, ff0 at 128..255, 000 at 896..1023, and 000 throughout blanking. Without the macro, rgb is always 000.
